// File: rtl/seg7_pkg.sv
// seg7_pkg: constants and types shared by the 7-segment driver and reader.
// Patterns are written a..g left to right (index 0 = a, 6 = g), active low,
// so a 0 bit means the segment is lit.
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    S_WAIT,
    S_HOLD
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational inverse of the driver's BCD table.
//   i_seg   [0:6] segment pattern a..g, active low
//   o_bcd   [3:0] decoded digit (0 for blank, BCD_INVALID for unknown)
//   o_blank       pattern is all segments off
//   o_err         pattern is not a digit and not blank
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [0:6] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_blank,
  output logic       o_err
);

  always_comb begin
    o_bcd   = 4'd0;
    o_blank = 1'b0;
    o_err   = 1'b0;
    case (i_seg)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: o_blank = 1'b1;
      default: begin
        o_bcd = BCD_INVALID;
        o_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/segment7_reader.sv
// segment7_reader: recovers BCD digits from a multiplexed active-low
// 7-segment bus and publishes a coherent word once every digit was seen.
//   clk, rst     clock, async active-high reset
//   seg_in[0:6]  segment lines a..g, active low, asynchronous
//   an_in        anode enables, active low, asynchronous
//   bcd_out      digit i in [4i+3:4i]
//   blank_out    digit i was blank in the last frame
//   err_out      digit i was an unknown pattern in the last frame
//   frame_valid  1-cycle pulse when the three outputs above update
//   sync_err     1-cycle pulse on a stable anode value with >1 bit low
module segment7_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_valid,
  output logic                    sync_err
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int SW = NUM_DIGITS + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [0:6]            r_seg_s1, r_seg_s2;
  logic [NUM_DIGITS-1:0] r_an_s1, r_an_s2;
  logic [SW-1:0]         r_prev;
  logic [CW-1:0]         r_cnt;
  state_t                r_state;

  logic [NUM_DIGITS-1:0][3:0] r_sh_bcd, r_bcd;
  logic [NUM_DIGITS-1:0]      r_sh_blank, r_sh_err, r_blank, r_err, r_seen;
  logic                       r_frame_valid, r_sync_err;

  logic [SW-1:0]         w_cur;
  logic                  w_same, w_eval, w_one, w_multi, w_cap;
  logic [CW-1:0]         w_cnt_nxt;
  logic [NUM_DIGITS-1:0] w_an_act;
  logic [3:0]            w_dec_bcd;
  logic                  w_dec_blank, w_dec_err;

  seg7_pattern_decode u_dec (
    .i_seg   (r_seg_s2),
    .o_bcd   (w_dec_bcd),
    .o_blank (w_dec_blank),
    .o_err   (w_dec_err)
  );

  assign w_cur     = {r_an_s2, r_seg_s2};
  assign w_same    = (w_cur == r_prev);
  assign w_cnt_nxt = !w_same ? '0 : (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
  // Evaluate on the cycle whose sample completes the STABLE_CYCLES-long run,
  // so the capture lands STABLE_CYCLES+2 cycles after the pins change.
  assign w_eval    = (r_state == S_WAIT) && w_same && (w_cnt_nxt == CNT_MAX);
  assign w_an_act  = ~r_an_s2;
  assign w_one     = $onehot(w_an_act);
  assign w_multi   = (w_an_act != '0) && !w_one;
  assign w_cap     = w_eval && w_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1      <= '1;
      r_seg_s2      <= '1;
      r_an_s1       <= '1;
      r_an_s2       <= '1;
      r_prev        <= '1;
      r_cnt         <= '0;
      r_state       <= S_WAIT;
      r_sh_bcd      <= '0;
      r_sh_blank    <= '0;
      r_sh_err      <= '0;
      r_seen        <= '0;
      r_bcd         <= '0;
      r_blank       <= '1;
      r_err         <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_an_s1    <= an_in;
      r_an_s2    <= r_an_s1;
      r_prev     <= w_cur;
      r_cnt      <= w_cnt_nxt;
      r_sync_err <= w_eval && w_multi;

      if (!w_same)
        r_state <= S_WAIT;
      else if (w_eval && (w_one || w_multi))
        r_state <= S_HOLD;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap && w_an_act[i]) begin
          r_sh_bcd[i]   <= w_dec_bcd;
          r_sh_blank[i] <= w_dec_blank;
          r_sh_err[i]   <= w_dec_err;
        end
      end

      // seen goes all ones on the completing capture; the next cycle
      // publishes. No capture can coincide since the FSM sits in S_HOLD.
      r_frame_valid <= &r_seen;
      if (&r_seen) begin
        r_bcd   <= r_sh_bcd;
        r_blank <= r_sh_blank;
        r_err   <= r_sh_err;
        r_seen  <= '0;
      end else begin
        r_seen <= r_seen | (w_cap ? w_an_act : '0);
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign blank_out   = r_blank;
  assign err_out     = r_err;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_segment7_reader.sv
module tb_segment7_reader;
  localparam int ND = 4;
  localparam int SC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:6]       seg_in;
  logic [ND-1:0]    an_in;
  logic [4*ND-1:0]  bcd_out;
  logic [ND-1:0]    blank_out, err_out;
  logic             frame_valid, sync_err;

  segment7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .blank_out(blank_out), .err_out(err_out),
    .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
  } frame_t;

  logic [0:6] tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100};

  frame_t exp_q[$];
  frame_t last_frame;
  bit     have_last = 0;
  int     exp_sync = 0;
  int     checks = 0, errors = 0;

  // reference model: what each digit last showed, which digits were shown
  int              m_val   [ND];
  logic [ND-1:0]   m_seen;
  logic [ND+6:0]   last_pat;

  // A stimulus segment is a constant {an,seg} held for dur cycles, always
  // different from its predecessor. It counts once it is held SC cycles.
  task automatic model_seg(input logic [ND-1:0] an, input logic [0:6] seg, input int dur);
    int idx;
    frame_t f;
    if (dur < SC) return;
    if (an == '1) return;
    if ($countones(~an) > 1) begin
      exp_sync++;
      return;
    end
    idx = 0;
    for (int i = 0; i < ND; i++) if (!an[i]) idx = i;
    m_val[idx] = -2;                       // unknown pattern
    if (seg == 7'b1111111) m_val[idx] = -1; // blank
    for (int v = 0; v < 10; v++) if (seg == tab[v]) m_val[idx] = v;
    m_seen[idx] = 1'b1;
    if (m_seen == '1) begin
      for (int i = 0; i < ND; i++) begin
        f.bcd[4*i +: 4] = (m_val[i] >= 0) ? 4'(m_val[i]) : (m_val[i] == -1) ? 4'h0 : 4'hF;
        f.blank[i]      = (m_val[i] == -1);
        f.err[i]        = (m_val[i] == -2);
      end
      exp_q.push_back(f);
      last_frame = f;
      have_last  = 1;
      m_seen     = '0;
    end
  endtask

  task automatic drive(input logic [ND-1:0] an, input logic [0:6] seg, input int dur);
    model_seg(an, seg, dur);
    an_in    = an;
    seg_in   = seg;
    last_pat = {an, seg};
    repeat (dur) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap(input int dur);
    drive('1, 7'b1111111, dur);
  endtask

  task automatic scan4(input int v0, input int v1, input int v2, input int v3);
    drive(4'b1110, tab[v0], 10); gap(2);
    drive(4'b1101, tab[v1], 10); gap(2);
    drive(4'b1011, tab[v2], 10); gap(2);
    drive(4'b0111, tab[v3], 10); gap(2);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    an_in  = 4'($urandom);
    seg_in = 7'($urandom);
    m_seen = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bcd_out !== '0 || blank_out !== '1 || err_out !== '0 || frame_valid !== 0 || sync_err !== 0) begin
      errors++;
      $display("FAIL reset_state: got bcd=%h blank=%b err=%b fv=%b se=%b, want bcd=0000 blank=1111 err=0000 fv=0 se=0",
               bcd_out, blank_out, err_out, frame_valid, sync_err);
    end
    an_in    = '1;
    seg_in   = 7'b1111111;
    last_pat = '1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // monitor: pops an expectation whenever the DUT presents a pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame: unexpected frame_valid bcd=%h blank=%b err=%b", bcd_out, blank_out, err_out);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          if ({bcd_out, blank_out, err_out} !== e) begin
            errors++;
            $display("FAIL frame: got bcd=%h blank=%b err=%b, want bcd=%h blank=%b err=%b",
                     bcd_out, blank_out, err_out, e.bcd, e.blank, e.err);
          end
        end
      end
      if (sync_err) begin
        checks++;
        if (exp_sync == 0) begin
          errors++;
          $display("FAIL sync_err: unexpected pulse, pending expected=0");
        end else exp_sync--;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ND-1:0] an;
    logic [0:6]    seg;
    int            r;
    an_in = '1; seg_in = 7'b1111111; rst = 1'b1;
    last_pat = '1;
    for (int i = 0; i < ND; i++) m_val[i] = 0;
    m_seen = '0;
    #1;
    do_reset();

    // clean scan, twice
    gap(4);
    scan4(3, 0, 2, 1);
    scan4(3, 0, 2, 1);
    gap(10);
    checks++;
    if (bcd_out !== 16'h1203 || blank_out !== 4'b0000 || err_out !== 4'b0000) begin
      errors++;
      $display("FAIL clean_scan: got bcd=%h blank=%b err=%b, want bcd=1203 blank=0000 err=0000",
               bcd_out, blank_out, err_out);
    end

    // short dwell: digit 2 for 3 cycles must not complete the frame
    drive(4'b1110, tab[5], 10); gap(2);
    drive(4'b1101, tab[6], 10); gap(2);
    drive(4'b0111, tab[7], 10); gap(2);
    drive(4'b1011, tab[2], 3);  gap(10);
    drive(4'b1011, tab[2], 4);  gap(10);

    // blank and invalid patterns
    drive(4'b1110, 7'b1111111, 10); gap(2);
    drive(4'b1101, 7'b1010101, 10); gap(2);
    drive(4'b1011, tab[8], 10);     gap(2);
    drive(4'b0111, tab[9], 10);     gap(10);
    checks++;
    if (bcd_out !== 16'h98F0 || blank_out !== 4'b0001 || err_out !== 4'b0010) begin
      errors++;
      $display("FAIL blank_invalid: got bcd=%h blank=%b err=%b, want bcd=98f0 blank=0001 err=0010",
               bcd_out, blank_out, err_out);
    end

    // anode fault then normal scan
    drive(4'b1100, tab[8], 6); gap(4);
    scan4(4, 5, 6, 7);
    gap(10);

    // reset mid-frame
    drive(4'b1110, tab[1], 10); gap(2);
    drive(4'b1101, tab[1], 10); gap(2);
    drive(4'b1011, tab[1], 10); gap(10);
    do_reset();
    gap(2);
    drive(4'b0111, tab[9], 10); gap(2);
    drive(4'b1110, tab[8], 10); gap(2);
    drive(4'b1101, tab[7], 10); gap(2);
    drive(4'b1011, tab[6], 10); gap(10);

    // randomized segments
    for (int k = 0; k < 400; k++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r <= 6)      an = ~(4'(1) << $urandom_range(0, ND - 1));
        else if (r <= 8) an = '1;
        else             an = 4'($urandom);
        r = $urandom_range(0, 9);
        if (r <= 7)      seg = tab[$urandom_range(0, 9)];
        else if (r == 8) seg = 7'b1111111;
        else             seg = 7'($urandom);
      end while ({an, seg} == last_pat);
      drive(an, seg, $urandom_range(1, 9));
    end
    if (last_pat == '1) drive(4'b1110, tab[0], 1);
    gap(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_pending: got %0d missing frames, want 0", exp_q.size());
    end
    checks++;
    if (exp_sync != 0) begin
      errors++;
      $display("FAIL sync_pending: got %0d missing sync_err pulses, want 0", exp_sync);
    end
    if (have_last) begin
      checks++;
      if ({bcd_out, blank_out, err_out} !== last_frame) begin
        errors++;
        $display("FAIL hold: got bcd=%h blank=%b err=%b, want bcd=%h blank=%b err=%b",
                 bcd_out, blank_out, err_out, last_frame.bcd, last_frame.blank, last_frame.err);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segment7_reader.md
Name: segment7_reader

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment driver.
- Samples a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and recovers the displayed BCD digits.
- Used as a loopback checker on the display path and as a front end for reading external 7-segment displays.
- Publishes a coherent multi-digit BCD word once per completed scan frame.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines); legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- seg_in  input  [0:6]  segment lines a..g (index 0 = a, 6 = g), active low, asynchronous to clk.
- an_in  input  NUM_DIGITS  anode enables, active low; bit i selects digit i; asynchronous to clk.
- bcd_out  output  4*NUM_DIGITS  recovered digits; digit i in bits [4i+3:4i].
- blank_out  output  NUM_DIGITS  digit i was blank (all segments off) in the last frame.
- err_out  output  NUM_DIGITS  digit i showed an unrecognised pattern in the last frame.
- frame_valid  output  1  one-cycle pulse when bcd_out, blank_out and err_out update.
- sync_err  output  1  one-cycle pulse when a stable anode value has more than one bit low.

Behaviour:
- Encoding (seg_in a..g, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- Synchronisation: seg_in and an_in each pass through 2 flops. Both flop stages reset to all ones (inactive).
- Stability counter: compares the synchronized {an,seg} with the previous cycle's value.
  - Equal: counter increments, saturating at STABLE_CYCLES-1.
  - Different: counter clears to 0 and the FSM returns to S_WAIT.
- FSM, two states:
  - S_WAIT: when the counter reaches STABLE_CYCLES-1, evaluate the anode value.
    - Exactly one bit low (digit i): capture digit i and go to S_HOLD.
    - All bits high (inter-digit blanking): stay in S_WAIT; no capture, no error.
    - More than one bit low: pulse sync_err for 1 cycle and go to S_HOLD; no capture.
  - S_HOLD: no further captures or sync_err pulses until {an,seg} changes. On change, go to S_WAIT with the counter at 0.
- Capture of digit i writes the shadow registers and sets seen[i]:
  - Valid 0..9: shadow bcd = value, blank = 0, err = 0.
  - Blank pattern: bcd = 0, blank = 1, err = 0.
  - Any other pattern: bcd = 4'hF, blank = 0, err = 1.
- Repeated capture of the same digit within a frame overwrites its shadow entry (latest wins).
- Frame completion:
  - Condition: a capture at cycle T makes seen all ones.
  - At T+1: bcd_out, blank_out and err_out load from the shadow registers together, frame_valid = 1 for exactly that cycle, and seen clears to 0.
  - Outputs hold between frames.
- Latency: a new stable digit is captured STABLE_CYCLES+2 cycles after it appears at the pins.
- Reset:
  - bcd_out = 0, blank_out = all ones, err_out = 0, frame_valid = 0, sync_err = 0.
  - Shadow registers, seen and counter = 0; FSM = S_WAIT.
- Reset mid-frame discards partial captures. The first frame_valid after reset requires every digit to be captured.
- A digit that never appears stalls frame completion indefinitely. This is intended; there is no timeout.
- NUM_DIGITS=1: every capture completes a frame.

Decomposition:
- Package seg7_pkg, shared with the existing driver:
  - the ten digit pattern constants and the BLANK pattern (7'b1111111)
  - the BCD_INVALID constant (4'hF)
  - the FSM state typedef {S_WAIT, S_HOLD}
- Sub-module seg7_pattern_decode: purely combinational 7-bit pattern to {bcd[3:0], blank, err}. It is the exact inverse of the driver table and is instantiated once.

Test Plan:
- Reset: assert rst with arbitrary inputs -> bcd_out=0x0000, blank_out=4'b1111, err_out=0, no pulses.
- Clean scan: scan digits 3,0,2,1 (an_in 1110,1101,1011,0111), 10 cycles each with 2-cycle all-high gaps -> one frame_valid per scan, bcd_out=0x1203, blank_out=0, err_out=0.
- Short dwell: digit 2 held 3 cycles with STABLE_CYCLES=4 -> no capture, no frame_valid. Hold it 4 or more cycles -> captured.
- Blank and invalid: digit 0 = 1111111, digit 1 = 1010101, digits 2–3 valid 8 and 9 -> bcd_out=0x98F0, blank_out=0001, err_out=0010.
- Anode fault: an_in=1100 held 6 cycles -> exactly one sync_err pulse, seen unchanged; the next valid scan completes normally.
- Reset mid-frame: capture digits 0–2, assert rst, then scan all four -> first frame_valid only after all four are captured post-reset.
